// File: rtl/host_memory_arbiter.sv
// host_memory_arbiter
//
// Lets two Avalon-MM masters share one single-port on-chip host memory
// (DEPTH words, one-cycle synchronous read). Port A is the soft CPU data
// master. Port B is the cartridge-bus DMA/emulation engine. At most one
// transaction is granted per clock, using round-robin arbitration on contention.
//
// Ports:
//   clk, reset          single clock; asynchronous active-high reset
//   a_* / b_*           Avalon slave ports: address, byteenable, read, write,
//                       writedata in; waitrequest, readdata, readdatavalid out
//   mem_*               RAM drive: address, byteenable, chipselect, write,
//                       writedata, clken (tied 1), reset_req (tied 0);
//                       mem_readdata is the RAM q, one cycle after sampling
//
// Accesses at or above DEPTH are acknowledged without selecting the RAM.
// Out-of-range writes are dropped and out-of-range reads return zero.
module host_memory_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DEPTH  = 7168
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] a_address,
  input  logic [3:0]        a_byteenable,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [DATA_W-1:0] a_writedata,
  output logic              a_waitrequest,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,

  input  logic [ADDR_W-1:0] b_address,
  input  logic [3:0]        b_byteenable,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [DATA_W-1:0] b_writedata,
  output logic              b_waitrequest,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  output logic              mem_reset_req,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam logic GrantA = 1'b0;
  localparam logic GrantB = 1'b1;

  // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DepthLimit = (ADDR_W + 1)'(DEPTH);

  logic a_req;
  logic b_req;
  logic grant_a;
  logic grant_b;
  logic granted;
  logic sel_read;
  logic sel_write;
  logic in_range;
  logic read_accept;

  logic last_grant_q;
  logic last_grant_d;
  logic tag_valid_q;
  logic tag_valid_d;
  logic tag_port_q;
  logic tag_port_d;
  logic tag_oor_q;
  logic tag_oor_d;

  logic [DATA_W-1:0] tag_data;

  assign a_req = a_read | a_write;
  assign b_req = b_read | b_write;

  // Grants are forced off while reset is high. Both ports then see
  // waitrequest immediately, without waiting for a clock edge.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      if (a_req && b_req) begin
        if (last_grant_q == GrantB) begin
          grant_a = 1'b1;
        end else begin
          grant_b = 1'b1;
        end
      end else begin
        grant_a = a_req;
        grant_b = b_req;
      end
    end
  end

  assign granted = grant_a | grant_b;

  assign a_waitrequest = ~grant_a;
  assign b_waitrequest = ~grant_b;

  // With no grant, the mux rests on port A. Chipselect and write are still
  // qualified by the grant.
  always_comb begin
    mem_address    = a_address;
    mem_byteenable = a_byteenable;
    mem_writedata  = a_writedata;
    sel_read       = a_read;
    sel_write      = a_write;
    if (grant_b) begin
      mem_address    = b_address;
      mem_byteenable = b_byteenable;
      mem_writedata  = b_writedata;
      sel_read       = b_read;
      sel_write      = b_write;
    end
  end

  assign in_range       = {1'b0, mem_address} < DepthLimit;
  assign mem_chipselect = granted & in_range;
  assign mem_write      = granted & sel_write;
  assign mem_clken      = 1'b1;
  assign mem_reset_req  = 1'b0;

  // A request with both read and write set is serviced as a write only.
  assign read_accept = granted & sel_read & ~sel_write;

  always_comb begin
    last_grant_d = last_grant_q;
    if (granted) begin
      last_grant_d = grant_b ? GrantB : GrantA;
    end
  end

  // The tag follows the read pipeline. It is rewritten every cycle, so it
  // clears itself when no read is accepted.
  always_comb begin
    tag_valid_d = read_accept;
    tag_port_d  = grant_b;
    tag_oor_d   = ~in_range;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= GrantB;
      tag_valid_q  <= 1'b0;
      tag_port_q   <= GrantA;
      tag_oor_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      tag_valid_q  <= tag_valid_d;
      tag_port_q   <= tag_port_d;
      tag_oor_q    <= tag_oor_d;
    end
  end

  // Out-of-range reads never selected the RAM, so q holds stale data and
  // must be masked.
  assign tag_data = tag_oor_q ? '0 : mem_readdata;

  always_comb begin
    a_readdatavalid = tag_valid_q & (tag_port_q == GrantA);
    b_readdatavalid = tag_valid_q & (tag_port_q == GrantB);
    a_readdata      = a_readdatavalid ? tag_data : '0;
    b_readdata      = b_readdatavalid ? tag_data : '0;
  end

endmodule

// File: tb/tb_host_memory_arbiter.sv
module tb_host_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic [12:0] a_address, b_address;
  logic [3:0]  a_byteenable, b_byteenable;
  logic        a_read, a_write, b_read, b_write;
  logic [31:0] a_writedata, b_writedata;
  logic        a_waitrequest, b_waitrequest;
  logic [31:0] a_readdata, b_readdata;
  logic        a_readdatavalid, b_readdatavalid;

  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken, mem_reset_req;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  host_memory_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .a_address       (a_address),
    .a_byteenable    (a_byteenable),
    .a_read          (a_read),
    .a_write         (a_write),
    .a_writedata     (a_writedata),
    .a_waitrequest   (a_waitrequest),
    .a_readdata      (a_readdata),
    .a_readdatavalid (a_readdatavalid),
    .b_address       (b_address),
    .b_byteenable    (b_byteenable),
    .b_read          (b_read),
    .b_write         (b_write),
    .b_writedata     (b_writedata),
    .b_waitrequest   (b_waitrequest),
    .b_readdata      (b_readdata),
    .b_readdatavalid (b_readdatavalid),
    .mem_address     (mem_address),
    .mem_byteenable  (mem_byteenable),
    .mem_chipselect  (mem_chipselect),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .mem_clken       (mem_clken),
    .mem_reset_req   (mem_reset_req),
    .mem_readdata    (mem_readdata)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle synchronous read, byte-lane writes, and a fixed
  // image loaded while reset is held.
  logic [31:0] ram [0:7167];

  always @(posedge clk) begin
    if (reset) begin
      ram[0]    <= 32'h0BADF00D;
      ram[16]   <= 32'hDEADBEEF;
      ram[256]  <= 32'hAAAAAAAA;
      ram[7167] <= 32'hC0DE1BFF;
      for (int i = 0; i < 4; i++) begin
        ram[32 + i] <= 32'hC0DE0020 + i;
        ram[48 + i] <= 32'hC0DE0030 + i;
        ram[64 + i] <= 32'hC0DE0040 + i;
      end
    end else if (mem_chipselect) begin
      if (mem_write) begin
        for (int i = 0; i < 4; i++) begin
          if (mem_byteenable[i]) ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
        end
      end
      mem_readdata <= ram[mem_address];
    end
  end

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: checks read responses against the scoreboard queues.
  always @(negedge clk) begin
    exp_t e;
    while (qa.size() > 0 && qa[0].due < cyc) begin
      total++; bad++;
      $display("FAIL a_missing: no strobe at cycle %0d, want data %h", qa[0].due, qa[0].data);
      void'(qa.pop_front());
    end
    while (qb.size() > 0 && qb[0].due < cyc) begin
      total++; bad++;
      $display("FAIL b_missing: no strobe at cycle %0d, want data %h", qb[0].due, qb[0].data);
      void'(qb.pop_front());
    end
    total++;
    if (a_readdatavalid === 1'b1) begin
      if (qa.size() == 0) begin
        bad++;
        $display("FAIL a_unexpected: strobe at cycle %0d data %h, want no strobe", cyc, a_readdata);
      end else begin
        e = qa.pop_front();
        if (e.due != cyc || a_readdata !== e.data) begin
          bad++;
          $display("FAIL a_read: cycle %0d data %h, want cycle %0d data %h",
                   cyc, a_readdata, e.due, e.data);
        end
      end
    end else if (a_readdatavalid !== 1'b0 || a_readdata !== 32'h0) begin
      bad++;
      $display("FAIL a_idle: cycle %0d valid %b data %h, want 0 and 0",
               cyc, a_readdatavalid, a_readdata);
    end
    total++;
    if (b_readdatavalid === 1'b1) begin
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL b_unexpected: strobe at cycle %0d data %h, want no strobe", cyc, b_readdata);
      end else begin
        e = qb.pop_front();
        if (e.due != cyc || b_readdata !== e.data) begin
          bad++;
          $display("FAIL b_read: cycle %0d data %h, want cycle %0d data %h",
                   cyc, b_readdata, e.due, e.data);
        end
      end
    end else if (b_readdatavalid !== 1'b0 || b_readdata !== 32'h0) begin
      bad++;
      $display("FAIL b_idle: cycle %0d valid %b data %h, want 0 and 0",
               cyc, b_readdatavalid, b_readdata);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: cycle %0d got %h, want %h", name, cyc, got, want);
    end
  endtask

  // Waits until mid-cycle, then checks the combinational grant outputs.
  task automatic grant_chk(input string name, input logic want_wa, input logic want_wb);
    #3;
    chk({name, "_a_wait"}, {31'b0, a_waitrequest}, {31'b0, want_wa});
    chk({name, "_b_wait"}, {31'b0, b_waitrequest}, {31'b0, want_wb});
  endtask

  task automatic drive_a(input logic rd, input logic wr, input logic [12:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
    a_read = rd; a_write = wr; a_address = addr; a_byteenable = be; a_writedata = wd;
  endtask

  task automatic drive_b(input logic rd, input logic wr, input logic [12:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
    b_read = rd; b_write = wr; b_address = addr; b_byteenable = be; b_writedata = wd;
  endtask

  task automatic exp_a(input logic [31:0] d);
    exp_t e;
    e.data = d; e.due = cyc + 1;
    qa.push_back(e);
  endtask

  task automatic exp_b(input logic [31:0] d);
    exp_t e;
    e.data = d; e.due = cyc + 1;
    qb.push_back(e);
  endtask

  initial begin
    drive_a(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    drive_b(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    #1 reset = 1'b1;
    drive_a(1'b1, 1'b0, 13'h10, 4'hF, 32'h0);
    drive_b(1'b1, 1'b0, 13'h30, 4'hF, 32'h0);
    @(posedge clk);
    grant_chk("reset", 1'b1, 1'b1);
    chk("reset_cs", {31'b0, mem_chipselect}, 32'h0);
    chk("reset_we", {31'b0, mem_write}, 32'h0);
    next_cycle();
    next_cycle();

    // Contention from reset: A wins first, and each loser holds its command.
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) next_cycle();
      drive_a(1'b1, 1'b0, 13'h20 + 13'((i + 1) / 2), 4'hF, 32'h0);
      drive_b(1'b1, 1'b0, 13'h30 + 13'(i / 2), 4'hF, 32'h0);
      if (i % 2 == 0) begin
        grant_chk("contend", 1'b0, 1'b1);
        exp_a(32'hC0DE0020 + 32'((i + 1) / 2));
      end else begin
        grant_chk("contend", 1'b1, 1'b0);
        exp_b(32'hC0DE0030 + 32'(i / 2));
      end
    end
    next_cycle();
    drive_b(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    grant_chk("contend_tail", 1'b0, 1'b1);
    exp_a(32'hC0DE0023);

    // Single read.
    next_cycle();
    drive_a(1'b1, 1'b0, 13'h10, 4'hF, 32'h0);
    grant_chk("single", 1'b0, 1'b1);
    exp_a(32'hDEADBEEF);

    // Byte-enable write from B, then an A read of the same word.
    next_cycle();
    drive_a(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    drive_b(1'b0, 1'b1, 13'h100, 4'b0101, 32'h11223344);
    grant_chk("be_write", 1'b1, 1'b0);
    chk("be_cs", {31'b0, mem_chipselect}, 32'h1);
    chk("be_we", {31'b0, mem_write}, 32'h1);
    chk("be_addr", {19'b0, mem_address}, 32'h100);
    chk("be_be", {28'b0, mem_byteenable}, 32'h5);
    chk("be_wd", mem_writedata, 32'h11223344);
    next_cycle();
    drive_b(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    drive_a(1'b1, 1'b0, 13'h100, 4'hF, 32'h0);
    grant_chk("be_read", 1'b0, 1'b1);
    exp_a(32'hAA22AA44);

    // Range boundary and out-of-range accesses.
    next_cycle();
    drive_a(1'b1, 1'b0, 13'h1BFF, 4'hF, 32'h0);
    grant_chk("last_word", 1'b0, 1'b1);
    chk("last_word_cs", {31'b0, mem_chipselect}, 32'h1);
    exp_a(32'hC0DE1BFF);
    next_cycle();
    drive_a(1'b0, 1'b1, 13'h1C00, 4'hF, 32'h12345678);
    grant_chk("oor_write", 1'b0, 1'b1);
    chk("oor_write_cs", {31'b0, mem_chipselect}, 32'h0);
    next_cycle();
    drive_a(1'b1, 1'b0, 13'h1C00, 4'hF, 32'h0);
    grant_chk("oor_read", 1'b0, 1'b1);
    chk("oor_read_cs", {31'b0, mem_chipselect}, 32'h0);
    exp_a(32'h0);
    next_cycle();
    drive_a(1'b1, 1'b0, 13'h1FFF, 4'hF, 32'h0);
    grant_chk("oor_top", 1'b0, 1'b1);
    chk("oor_top_cs", {31'b0, mem_chipselect}, 32'h0);
    exp_a(32'h0);
    next_cycle();
    drive_a(1'b1, 1'b0, 13'h0, 4'hF, 32'h0);
    grant_chk("word0", 1'b0, 1'b1);
    exp_a(32'h0BADF00D);

    // Idle: the memory side rests on port A's command.
    next_cycle();
    drive_a(1'b0, 1'b0, 13'h55, 4'h3, 32'h0);
    drive_b(1'b0, 1'b0, 13'h77, 4'hC, 32'h0);
    grant_chk("idle", 1'b1, 1'b1);
    chk("idle_addr", {19'b0, mem_address}, 32'h55);
    chk("idle_cs", {31'b0, mem_chipselect}, 32'h0);

    // B streams while A is idle. A then interrupts for exactly one cycle.
    next_cycle();
    drive_b(1'b1, 1'b0, 13'h40, 4'hF, 32'h0);
    grant_chk("stream0", 1'b1, 1'b0);
    exp_b(32'hC0DE0040);
    next_cycle();
    drive_b(1'b1, 1'b0, 13'h41, 4'hF, 32'h0);
    grant_chk("stream1", 1'b1, 1'b0);
    exp_b(32'hC0DE0041);
    next_cycle();
    drive_a(1'b1, 1'b0, 13'h10, 4'hF, 32'h0);
    drive_b(1'b1, 1'b0, 13'h42, 4'hF, 32'h0);
    grant_chk("hold_a", 1'b0, 1'b1);
    exp_a(32'hDEADBEEF);
    next_cycle();
    drive_a(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    grant_chk("hold_b", 1'b1, 1'b0);
    exp_b(32'hC0DE0042);

    // Reset in the cycle after an accepted read: that read is lost.
    next_cycle();
    drive_b(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    drive_a(1'b1, 1'b0, 13'h20, 4'hF, 32'h0);
    grant_chk("pre_reset", 1'b0, 1'b1);
    next_cycle();
    reset = 1'b1;
    drive_a(1'b1, 1'b0, 13'h21, 4'hF, 32'h0);
    drive_b(1'b1, 1'b0, 13'h31, 4'hF, 32'h0);
    grant_chk("mid_reset", 1'b1, 1'b1);
    chk("mid_reset_rdv", {31'b0, a_readdatavalid}, 32'h0);
    chk("mid_reset_cs", {31'b0, mem_chipselect}, 32'h0);
    next_cycle();
    reset = 1'b0;
    drive_a(1'b1, 1'b0, 13'h20, 4'hF, 32'h0);
    drive_b(1'b1, 1'b0, 13'h30, 4'hF, 32'h0);
    grant_chk("post_reset", 1'b0, 1'b1);
    exp_a(32'hC0DE0020);
    next_cycle();
    drive_a(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    grant_chk("post_reset_b", 1'b1, 1'b0);
    exp_b(32'hC0DE0030);
    next_cycle();
    drive_b(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);

    repeat (3) next_cycle();
    chk("qa_drained", qa.size(), 32'h0);
    chk("qb_drained", qb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
